patch_fetch_arbiter: RTL
========================

Name: patch_fetch_arbiter

Overview:
- Shares one aggregator sender port between N_SRC word FIFOs (patch/query streams), so several producers can feed a single FETCH_WIDTH-word packer.
- Grants one source per packet, round-robin, and locks that grant for exactly FETCH_WIDTH dequeues so packets from different sources never interleave.
- Sits between the read side of the per-source FIFOs and the aggregator. Reports which source owns the packet in flight.

Parameters:
- DATA_WIDTH, 11: word width in bits.
- FETCH_WIDTH, 4: words per packet; must be >= 1.
- N_SRC, 4: number of requesting FIFOs; must be >= 2.
- ID_WIDTH, $clog2(N_SRC): width of the source index. Derived; do not override.

Ports:
- clk  in  1  single clock; the FIFO read side and the aggregator run on this clock.
- rst_n  in  1  reset, asynchronous, active-low.
- src_enable  in  N_SRC  per-source enable mask. Sampled only when a grant is made.
- src_data  in  N_SRC*DATA_WIDTH  flattened FWFT read data; source i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- src_empty_n  in  N_SRC  source i holds valid data when high.
- src_deq  out  N_SRC  dequeue strobe to source i. At most one bit is high at a time.
- agg_data  out  DATA_WIDTH  word presented to the aggregator.
- agg_empty_n  out  1  agg_data is valid.
- agg_deq  in  1  aggregator consumes agg_data.
- pkt_src  out  ID_WIDTH  index of the granted source. Registered and stable for the whole burst.
- pkt_start  out  1  one-cycle pulse in the first BURST cycle of each packet.
- busy  out  1  high while in BURST.

Behaviour:
- States: IDLE, BURST. Registers: state, grant (ID_WIDTH), last (ID_WIDTH), wcnt ($clog2(FETCH_WIDTH+1) bits).
- Reset values (async, rst_n low): state=IDLE, grant=0, last=N_SRC-1 (so source 0 has first priority), wcnt=0, pkt_src=0, pkt_start=0, busy=0. Outputs derived from state give src_deq=0 and agg_empty_n=0.
- Eligibility: source i is eligible when src_enable[i] and src_empty_n[i] are both high.
- IDLE: if any source is eligible, pick the first eligible index searching last+1, last+2, ... with wrap modulo N_SRC. On the next edge: grant and pkt_src take that index, wcnt=0, state=BURST, pkt_start=1. Otherwise stay in IDLE.
- BURST:
  - agg_data = src_data slice [grant].
  - agg_empty_n = src_empty_n[grant]. src_enable is ignored while in BURST.
  - src_deq[grant] = agg_deq & agg_empty_n. All other src_deq bits are 0.
  - An agg_deq while agg_empty_n is low is ignored and not forwarded.
- Counting: each forwarded dequeue increments wcnt.
  - On the forwarded dequeue with wcnt == FETCH_WIDTH-1: on the next edge state=IDLE, last=grant, wcnt=0.
- Latency:
  - One cycle from an eligible request in IDLE to BURST. agg_empty_n can rise in the first BURST cycle.
  - There is a mandatory one-cycle IDLE bubble between packets.
  - Peak throughput is FETCH_WIDTH words per FETCH_WIDTH+1 cycles.
- Source underrun mid-packet: the granted source may go empty. The arbiter holds the grant and waits indefinitely with agg_empty_n low. There is no timeout and no re-arbitration.
- Source disabled mid-packet (src_enable[grant] falls): the burst still completes. The mask takes effect at the next grant.
- Simultaneous requests: exactly one grant per arbitration. Fairness: a continuously eligible source waits at most N_SRC-1 packets.
- FETCH_WIDTH=1: every forwarded dequeue ends the burst.
- Reset mid-burst: immediate return to the reset values. Words already dequeued are lost; the FIFOs and the aggregator are reset by the same rst_n.
- pkt_start is registered and is high only in the first BURST cycle. busy = (state==BURST).

Decomposition:
- Shared package fetch_pkg: state enum (IDLE, BURST) and default constants DATA_WIDTH=11, FETCH_WIDTH=4. These are shared with the aggregator.
- One sub-module, rr_pick: combinational round-robin first-eligible search. Parameter N_SRC; inputs req[N_SRC] and last; outputs any and idx. It is verified standalone.

Test Plan:
- Single source: src0 streams 0,1,2,...; agg_deq held high; other sources empty. Required: agg sees 0..3, then a 1-cycle gap, then 4..7; pkt_src=0 throughout; pkt_start pulses once per packet.
- All four sources always eligible, each tagged with base value i*100. Required: packet order 0,1,2,3,0,...; each packet is 4 consecutive words from one source, e.g. 100,101,102,103.
- Underrun: src2 goes empty after 2 words of a granted packet for 5 cycles. Required: agg_empty_n low for those 5 cycles; grant stays 2; the remaining 2 words follow; no other src_deq bit rises.
- Mask: src_enable=4'b1010 with all sources eligible. Required: grants alternate 1,3,1,3. Clearing bit 1 mid-burst still completes that 4-word packet.
- Backpressure: agg_deq randomly toggled, with agg_deq asserted while agg_empty_n is low. Required: src_deq never asserts without agg_empty_n; word totals per source match.
- Reset mid-burst: assert rst_n low after 2 words. Required: all outputs are 0 during reset; the first grant after release goes to source 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: definitions shared between the patch fetch arbiter and the
// FETCH_WIDTH-word aggregator it feeds.
//   fetch_state_e : arbiter FSM state (IDLE waits for a request, BURST owns a packet)
//   DATA_WIDTH    : default word width in bits
//   FETCH_WIDTH   : default number of words per packet
package fetch_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } fetch_state_e;

  localparam int unsigned DATA_WIDTH  = 32'd11;
  localparam int unsigned FETCH_WIDTH = 32'd4;

endpackage

// File: rtl/patch_fetch_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search. Returns the first requesting
// index found by scanning last+1, last+2, ... modulo N_SRC, so the index
// after the previous winner has the highest priority and the previous winner
// itself the lowest.
//   req  in  N_SRC     request vector
//   last in  ID_WIDTH  index of the previous winner
//   any  out 1         at least one request is present
//   idx  out ID_WIDTH  winning index (0 when any is low)
module rr_pick #(
  parameter int unsigned N_SRC    = 32'd4,
  parameter int unsigned ID_WIDTH = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0]    req,
  input  logic [ID_WIDTH-1:0] last,
  output logic                any,
  output logic [ID_WIDTH-1:0] idx
);

  int cand;

  // Scan from the farthest candidate to the nearest; the nearest hit is
  // written last and therefore wins, which avoids a separate found flag.
  always_comb begin
    any  = 1'b0;
    idx  = {ID_WIDTH{1'b0}};
    cand = 0;
    for (int k = int'(N_SRC); k >= 1; k--) begin
      cand = (int'(last) + k) % int'(N_SRC);
      any  = any | req[cand[ID_WIDTH-1:0]];
      idx  = req[cand[ID_WIDTH-1:0]] ? cand[ID_WIDTH-1:0] : idx;
    end
  end

endmodule

// File: rtl/patch_fetch_arbiter.sv
// patch_fetch_arbiter: shares one aggregator sender port between N_SRC FWFT
// word FIFOs. One source is granted per packet in round-robin order and the
// grant is held for exactly FETCH_WIDTH forwarded dequeues, so packets never
// interleave. One IDLE bubble separates consecutive packets.
//   clk, rst_n   clock, asynchronous active-low reset
//   src_enable   per-source enable, only looked at when a grant is made
//   src_data     flattened FWFT data, source i at [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
//   src_empty_n  per-source data valid
//   src_deq      per-source dequeue strobe (at most one bit high)
//   agg_data     word presented to the aggregator (0 outside a burst)
//   agg_empty_n  agg_data valid
//   agg_deq      aggregator consumes agg_data
//   pkt_src      index of the granted source, stable through the burst
//   pkt_start    one-cycle pulse in the first cycle of each burst
//   busy         a packet is in flight
module patch_fetch_arbiter #(
  parameter int unsigned DATA_WIDTH  = fetch_pkg::DATA_WIDTH,
  parameter int unsigned FETCH_WIDTH = fetch_pkg::FETCH_WIDTH,
  parameter int unsigned N_SRC       = 32'd4,
  parameter int unsigned ID_WIDTH    = $clog2(N_SRC)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_SRC-1:0]            src_enable,
  input  logic [N_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [N_SRC-1:0]            src_empty_n,
  output logic [N_SRC-1:0]            src_deq,
  output logic [DATA_WIDTH-1:0]       agg_data,
  output logic                        agg_empty_n,
  input  logic                        agg_deq,
  output logic [ID_WIDTH-1:0]         pkt_src,
  output logic                        pkt_start,
  output logic                        busy
);

  import fetch_pkg::*;

  localparam int unsigned         CNT_W      = $clog2(FETCH_WIDTH + 32'd1);
  localparam logic [CNT_W-1:0]    LAST_WORD  = CNT_W'(FETCH_WIDTH - 32'd1);
  localparam logic [ID_WIDTH-1:0] LAST_RESET = ID_WIDTH'(N_SRC - 32'd1);

  fetch_state_e          state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0]   last_q, last_d;
  logic [ID_WIDTH-1:0]   pkt_src_q, pkt_src_d;
  logic [CNT_W-1:0]      wcnt_q, wcnt_d;
  logic                  pkt_start_q, pkt_start_d;

  logic [N_SRC-1:0]      req_s;
  logic                  any_s;
  logic [ID_WIDTH-1:0]   idx_s;
  logic                  in_burst_s;
  logic                  head_valid_s;
  logic [DATA_WIDTH-1:0] head_data_s;
  logic                  fwd_s;

  assign req_s = src_enable & src_empty_n;

  rr_pick #(
    .N_SRC   (N_SRC),
    .ID_WIDTH(ID_WIDTH)
  ) u_rr_pick (
    .req (req_s),
    .last(last_q),
    .any (any_s),
    .idx (idx_s)
  );

  // Select the head word and valid flag of the granted source (AND-OR mux).
  always_comb begin
    head_data_s  = {DATA_WIDTH{1'b0}};
    head_valid_s = 1'b0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      head_data_s  = head_data_s |
                     ((grant_q == ID_WIDTH'(i)) ? src_data[i*DATA_WIDTH +: DATA_WIDTH]
                                                : {DATA_WIDTH{1'b0}});
      head_valid_s = head_valid_s | ((grant_q == ID_WIDTH'(i)) & src_empty_n[i]);
    end
  end

  assign in_burst_s  = (state_q == BURST);
  assign agg_empty_n = in_burst_s & head_valid_s;
  assign agg_data    = in_burst_s ? head_data_s : {DATA_WIDTH{1'b0}};
  // A dequeue request against an empty head is dropped, never forwarded.
  assign fwd_s       = agg_empty_n & agg_deq;

  // Route the forwarded dequeue to the granted source only.
  always_comb begin
    src_deq = {N_SRC{1'b0}};
    for (int i = 0; i < int'(N_SRC); i++) begin
      src_deq[i] = fwd_s & (grant_q == ID_WIDTH'(i));
    end
  end

  // Next-state logic: grant in IDLE, count forwarded words in BURST.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    pkt_src_d   = pkt_src_q;
    wcnt_d      = wcnt_q;
    pkt_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_s) begin
          state_d     = BURST;
          grant_d     = idx_s;
          pkt_src_d   = idx_s;
          wcnt_d      = {CNT_W{1'b0}};
          pkt_start_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        if (fwd_s) begin
          if (wcnt_q == LAST_WORD) begin
            state_d = IDLE;
            last_d  = grant_q;
            wcnt_d  = {CNT_W{1'b0}};
          end else begin
            wcnt_d = wcnt_q + CNT_W'(1);
          end
        end else begin
          wcnt_d = wcnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; last resets to N_SRC-1 so source 0 wins the first grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= {ID_WIDTH{1'b0}};
      last_q      <= LAST_RESET;
      pkt_src_q   <= {ID_WIDTH{1'b0}};
      wcnt_q      <= {CNT_W{1'b0}};
      pkt_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      pkt_src_q   <= pkt_src_d;
      wcnt_q      <= wcnt_d;
      pkt_start_q <= pkt_start_d;
    end
  end

  assign pkt_src   = pkt_src_q;
  assign pkt_start = pkt_start_q;
  assign busy      = in_burst_s;

endmodule
